// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port RAM with synchronous write and combinational read.
// Optional macro RAM_BURST_BOUND_CHK_EN rejects bursts that would run past the top address.
module ram_burst_master #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              oob;
    logic              rd_load;
    logic              rd_taken;

`ifdef RAM_BURST_BOUND_CHK_EN
    logic [ADDR_W+LEN_W:0] end_addr;
    assign end_addr = {{(LEN_W+1){1'b0}}, cmd_addr} + {{(ADDR_W+1){1'b0}}, cmd_len};
    assign oob      = end_addr > {{(LEN_W+1){1'b0}}, {ADDR_W{1'b1}}};
`else
    assign oob = 1'b0;
`endif

    assign cmd_ready   = (state == IDLE) && rst_n;
    assign wdata_ready = (state == WRITE);
    assign mem_wr      = (state == WRITE) && wdata_valid;
    assign mem_addr    = addr_q;
    assign mem_wr_data = wdata;
    assign busy        = (state != IDLE);
    assign rd_taken    = rdata_valid && rdata_ready;
    // The output register can be refilled whenever it is empty or being drained this cycle.
    assign rd_load     = (state == READ) && (!rdata_valid || rdata_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_taken) rdata_valid <= 1'b0;
                    if (cmd_valid) begin
                        if (oob) begin
                            err <= 1'b1;
                        end else begin
                            addr_q <= cmd_addr;
                            cnt_q  <= cmd_len;
                            state  <= cmd_wr ? WRITE : READ;
                        end
                    end
                end
                WRITE: begin
                    if (rd_taken) rdata_valid <= 1'b0;
                    if (wdata_valid) begin
                        addr_q <= addr_q + 1'b1;
                        cnt_q  <= cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rd_load) begin
                        rdata       <= mem_rd_data;
                        rdata_valid <= 1'b1;
                        addr_q      <= addr_q + 1'b1;
                        cnt_q       <= cnt_q - 1'b1;
                        if (cnt_q == '0) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (rd_taken) begin
                        rdata_valid <= 1'b0;
                        done        <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
